// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA timing generator.
// Defaults describe 800x600@60 with a 40 MHz pixel clock.
package vga_pkg;

    // Counter widths.
    localparam int unsigned X_W = 11;
    localparam int unsigned Y_W = 10;

    // Default horizontal timing in pixel clocks.
    localparam int unsigned H_VISIBLE_DEF = 800;
    localparam int unsigned H_FRONT_DEF   = 40;
    localparam int unsigned H_SYNC_DEF    = 128;
    localparam int unsigned H_BACK_DEF    = 88;

    // Default vertical timing in lines.
    localparam int unsigned V_VISIBLE_DEF = 600;
    localparam int unsigned V_FRONT_DEF   = 1;
    localparam int unsigned V_SYNC_DEF    = 4;
    localparam int unsigned V_BACK_DEF    = 23;

    localparam int unsigned H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // One registered sample of every timing output.
    typedef struct packed {
        logic           hsync;
        logic           vsync;
        logic           active;
        logic           frame_start;
        logic           line_start;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } vga_out_t;

    localparam int unsigned VGA_OUT_W = $bits(vga_out_t);

    // Output bundle while held in reset or cleared: syncs at their inactive level.
    function automatic vga_out_t vga_idle(input logic h_pol, input logic v_pol);
        vga_out_t o;
        o       = '0;
        o.hsync = ~h_pol;
        o.vsync = ~v_pol;
        return o;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipeline with async active-low reset and synchronous clear.
// Every stage returns to RST_VAL on reset or clear so no stale data survives a restart.
module vga_delay_line #(
    parameter int unsigned       WIDTH   = 1,
    parameter int unsigned       DEPTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : gen_bypass
        assign q_o = d_i;
    end else begin : gen_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        // Shift one stage per clock, or load the idle value on clear.
        always_comb begin
            stage_d[0] = clr_i ? RST_VAL : d_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_d[i] = clr_i ? RST_VAL : stage_q[i-1];
            end
        end

        // Pipeline state.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= stage_d[i];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: free-running pixel/line counters with registered
// sync, active, position and start-of-line/frame decodes.
// Optional feature macro VGA_TIMING_LOOKAHEAD_EN adds fetch_* ports that lead the
// display outputs by LOOKAHEAD clocks (display outputs are delayed to match).
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT    = H_FRONT_DEF,
    parameter int unsigned H_SYNC     = H_SYNC_DEF,
    parameter int unsigned H_BACK     = H_BACK_DEF,
    parameter int unsigned V_VISIBLE  = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT    = V_FRONT_DEF,
    parameter int unsigned V_SYNC     = V_SYNC_DEF,
    parameter int unsigned V_BACK     = V_BACK_DEF,
    parameter logic        H_SYNC_POL = 1'b1,
    parameter logic        V_SYNC_POL = 1'b1,
    parameter int unsigned LOOKAHEAD  = 2
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           enable,
    output logic           hsync,
    output logic           vsync,
    output logic           active,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           frame_start,
`ifdef VGA_TIMING_LOOKAHEAD_EN
    output logic           line_start,
    output logic [X_W-1:0] fetch_x,
    output logic [Y_W-1:0] fetch_y,
    output logic           fetch_active
`else
    output logic           line_start
`endif
);

    localparam int unsigned H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOT - 1);
    localparam logic [X_W-1:0] H_VIS_END  = X_W'(H_VISIBLE);
    localparam logic [X_W-1:0] H_SYNC_BEG = X_W'(H_VISIBLE + H_FRONT);
    localparam logic [X_W-1:0] H_SYNC_END = X_W'(H_VISIBLE + H_FRONT + H_SYNC);

    localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOT - 1);
    localparam logic [Y_W-1:0] V_VIS_END  = Y_W'(V_VISIBLE);
    localparam logic [Y_W-1:0] V_SYNC_BEG = Y_W'(V_VISIBLE + V_FRONT);
    localparam logic [Y_W-1:0] V_SYNC_END = Y_W'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam vga_out_t IDLE = vga_idle(H_SYNC_POL, V_SYNC_POL);

    // Elaboration-time sanity checks on the configuration.
    if (H_TOT > 2 ** X_W) begin : gen_h_range_err
        $error("horizontal total does not fit the x counter");
    end
    if (V_TOT > 2 ** Y_W) begin : gen_v_range_err
        $error("vertical total does not fit the y counter");
    end
    if (LOOKAHEAD > H_TOT) begin : gen_lookahead_err
        $error("LOOKAHEAD longer than one line");
    end

    logic           run_q, run_d;
    logic [X_W-1:0] hc_q, hc_d;
    logic [Y_W-1:0] vc_q, vc_d;
    vga_out_t       dec_q, dec_d;
    vga_out_t       out_s;

    // Counter next state. run_q marks that the previous edge was also enabled, so the
    // first enabled edge after a clear only primes the pipeline and leaves (0,0) in place.
    always_comb begin
        run_d = enable;
        hc_d  = hc_q;
        vc_d  = vc_q;
        if (!enable) begin
            hc_d = '0;
            vc_d = '0;
        end else if (run_q) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
            end
        end
    end

    // Registered decode of the current counter state; idle until the counters are live.
    always_comb begin
        dec_d = IDLE;
        if (enable && run_q) begin
            dec_d.hsync       = ((hc_q >= H_SYNC_BEG) && (hc_q < H_SYNC_END)) ?
                                H_SYNC_POL : ~H_SYNC_POL;
            dec_d.vsync       = ((vc_q >= V_SYNC_BEG) && (vc_q < V_SYNC_END)) ?
                                V_SYNC_POL : ~V_SYNC_POL;
            dec_d.active      = (hc_q < H_VIS_END) && (vc_q < V_VIS_END);
            dec_d.frame_start = (hc_q == '0) && (vc_q == '0);
            dec_d.line_start  = (hc_q == '0);
            dec_d.x           = hc_q;
            dec_d.y           = vc_q;
        end
    end

    // Counter and decode registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
            hc_q  <= '0;
            vc_q  <= '0;
            dec_q <= IDLE;
        end else begin
            run_q <= run_d;
            hc_q  <= hc_d;
            vc_q  <= vc_d;
            dec_q <= dec_d;
        end
    end

`ifdef VGA_TIMING_LOOKAHEAD_EN
    logic [VGA_OUT_W-1:0] dly_s;

    vga_delay_line #(
        .WIDTH   (VGA_OUT_W),
        .DEPTH   (LOOKAHEAD),
        .RST_VAL (IDLE)
    ) u_delay_line (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .clr_i  (~enable),
        .d_i    (dec_q),
        .q_o    (dly_s)
    );

    assign fetch_x      = dec_q.x;
    assign fetch_y      = dec_q.y;
    assign fetch_active = dec_q.active;
    assign out_s        = dly_s;
`else
    assign out_s        = dec_q;
`endif

    assign hsync       = out_s.hsync;
    assign vsync       = out_s.vsync;
    assign active      = out_s.active;
    assign x           = out_s.x;
    assign y           = out_s.y;
    assign frame_start = out_s.frame_start;
    assign line_start  = out_s.line_start;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing using a reduced raster (32 x 19) so whole frames run quickly.
// A position-count model predicts every output each cycle; directed checks pin the model.
module tb_vga_timing;
    import vga_pkg::*;

    localparam int HV = 20, HF = 3, HS = 5, HB = 4, HT = 32;
    localparam int VV = 10, VF = 2, VS = 3, VB = 4, VT = 19;
    localparam int FRAME = HT * VT;  // 608
    localparam int LA = 2;
    localparam bit HPOL = 1'b1, VPOL = 1'b1;
`ifdef VGA_TIMING_LOOKAHEAD_EN
    localparam int EXTRA = LA;
`else
    localparam int EXTRA = 0;
`endif

    logic clock, reset_n, enable;
    logic hsync, vsync, active, frame_start, line_start;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
`ifdef VGA_TIMING_LOOKAHEAD_EN
    logic [X_W-1:0] fetch_x;
    logic [Y_W-1:0] fetch_y;
    logic fetch_active;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_on = 0;
    int k = 0;  // consecutive enabled edges since the last reset/clear

    vga_timing #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL), .LOOKAHEAD(LA)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .hsync       (hsync),
        .vsync       (vsync),
        .active      (active),
        .x           (x),
        .y           (y),
        .frame_start (frame_start),
`ifdef VGA_TIMING_LOOKAHEAD_EN
        .line_start  (line_start),
        .fetch_x     (fetch_x),
        .fetch_y     (fetch_y),
        .fetch_active(fetch_active)
`else
        .line_start  (line_start)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Raster position n (pixel index since frame start); negative means idle outputs.
    function automatic vga_out_t model_at(int n);
        vga_out_t o;
        int hc, vc;
        o = '0;
        o.hsync = !HPOL;
        o.vsync = !VPOL;
        if (n < 0) return o;
        hc = n % HT;
        vc = (n / HT) % VT;
        o.active      = (hc < HV) && (vc < VV);
        o.hsync       = (hc >= HV + HF && hc < HV + HF + HS) ? HPOL : !HPOL;
        o.vsync       = (vc >= VV + VF && vc < VV + VF + VS) ? VPOL : !VPOL;
        o.frame_start = (hc == 0) && (vc == 0);
        o.line_start  = (hc == 0);
        o.x           = X_W'(hc);
        o.y           = Y_W'(vc);
        return o;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    // Model progress: count enabled edges; reset or a disabled edge restarts the count.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) k <= 0;
        else if (enable) k <= k + 1;
        else k <= 0;
    end

    // Continuous compare of every output against the model.
    always @(negedge clock) begin
        if (cmp_on) begin
            vga_out_t g, e;
            g = '{hsync, vsync, active, frame_start, line_start, x, y};
            e = model_at(k - 2 - EXTRA);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL outputs got=%h exp=%h k=%0d t=%0t", g, e, k, $time);
            end
`ifdef VGA_TIMING_LOOKAHEAD_EN
            e = model_at(k - 2);
            checks++;
            if ({fetch_x, fetch_y, fetch_active} !== {e.x, e.y, e.active}) begin
                errors++;
                $display("FAIL fetch got=%0d,%0d,%0b exp=%0d,%0d,%0b t=%0t",
                         fetch_x, fetch_y, fetch_active, e.x, e.y, e.active, $time);
            end
`endif
        end
    end

    int hs_cnt, vs_cnt, act_cnt, ls_cnt, fs_cnt, hs_min, hs_max, vs_min, vs_max;
    int fs_t0, fs_t1, px, py, wx, wy;
    bit found;

    initial begin
        reset_n = 1'b1;
        enable  = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        cmp_on = 1;
        chk("rst_hsync", hsync, 0);
        chk("rst_vsync", vsync, 0);
        chk("rst_active", active, 0);
        chk("rst_xy", {x, y}, 0);

        // Release with enable high: x=0,y=0 two clocks later, then x=1.
        reset_n = 1'b1;
        enable  = 1'b1;
        @(negedge clock);
        chk("first_edge_fs", frame_start, 0);
        @(negedge clock);
`ifdef VGA_TIMING_LOOKAHEAD_EN
        chk("fetch_lead_x0", fetch_x, 0);
        chk("fetch_lead_fs", frame_start, 0);
        repeat (LA) @(negedge clock);
`endif
        chk("start_x", x, 0);
        chk("start_y", y, 0);
        chk("start_active", active, 1);
        chk("start_fs", frame_start, 1);
        chk("start_ls", line_start, 1);
        @(negedge clock);
        chk("start_x1", x, 1);
        chk("start_fs_low", frame_start, 0);

        // Two whole frames of statistics.
        hs_cnt = 0; vs_cnt = 0; act_cnt = 0; ls_cnt = 0; fs_cnt = 0;
        hs_min = 9999; hs_max = -1; vs_min = 9999; vs_max = -1;
        fs_t0 = -1; fs_t1 = -1; px = 1; py = 0; wx = -1; wy = -1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clock);
            if (hsync) begin
                hs_cnt++;
                if (int'(x) < hs_min) hs_min = int'(x);
                if (int'(x) > hs_max) hs_max = int'(x);
            end
            if (vsync) begin
                vs_cnt++;
                if (int'(y) < vs_min) vs_min = int'(y);
                if (int'(y) > vs_max) vs_max = int'(y);
            end
            if (active) act_cnt++;
            if (line_start) ls_cnt++;
            if (frame_start) begin
                fs_cnt++;
                if (fs_t0 < 0) begin
                    fs_t0 = i;
                    wx = px;
                    wy = py;
                end else begin
                    fs_t1 = i;
                end
            end
            px = int'(x);
            py = int'(y);
        end
        chk("hsync_clocks", hs_cnt, 2 * HS * VT);
        chk("hsync_first_x", hs_min, 23);
        chk("hsync_last_x", hs_max, 27);
        chk("vsync_clocks", vs_cnt, 2 * 96);
        chk("vsync_first_y", vs_min, 12);
        chk("vsync_last_y", vs_max, 14);
        chk("active_clocks", act_cnt, 400);
        chk("line_starts", ls_cnt, 38);
        chk("frame_starts", fs_cnt, 2);
        chk("frame_period", fs_t1 - fs_t0, 608);
        chk("wrap_from", wx * 100 + wy, 31 * 100 + 18);

        // Drop enable in the middle of hsync and vsync for three clocks.
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clock);
            if (x == 26 && y == 13) found = 1;
        end
        chk("reach_26_13", found, 1);
        enable = 1'b0;
        @(negedge clock);
        chk("drop_hsync", hsync, 0);
        chk("drop_vsync", vsync, 0);
        chk("drop_xy", {x, y}, 0);
        repeat (2) @(negedge clock);
        enable = 1'b1;
        repeat (2 + EXTRA) @(negedge clock);
        chk("restart_fs", frame_start, 1);
        chk("restart_xy", {x, y}, 0);

        // Asynchronous reset mid-line, observed before any clock edge.
        repeat (30) @(negedge clock);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("async_xy", {x, y}, 0);
        chk("async_active", active, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Randomised enable drops and async resets against the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            if ($urandom_range(0, 299) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clock);
                enable = 1'b1;
            end else if ($urandom_range(0, 799) == 0) begin
                @(posedge clock);
                #($urandom_range(1, 4)) reset_n = 1'b0;
                @(negedge clock);
                reset_n = 1'b1;
            end
        end

        cmp_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
